glue_input_conditioner: RTL and testbench
=========================================

Name: glue_input_conditioner

Overview:
- Front end for the four glue-logic inputs in4..in7. Takes raw asynchronous pins, synchronises them into the 50 MHz clk domain, debounces them against the 1 MHz enable, and emits clean levels plus single-cycle edge strobes.
- Delivers the glue-logic input bus in conditioned form.
- Uses one clock domain only; the 1 MHz rate arrives as a clock-enable pulse, not as a second clock.

Parameters:
- N_IN, 4, number of input channels.
- DEB_TICKS, 10, number of consecutive tick_1MHz pulses an input must hold a new level before acceptance (10 us); legal range 1..255.
- CNT_W, 8, width of each per-channel debounce counter; must satisfy 2^CNT_W > DEB_TICKS.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_1MHz  in  1  one-clk-wide enable, nominally every 50 clk.
- in_raw  in  N_IN  raw asynchronous inputs (bit0 = in4 ... bit3 = in7).
- in_clean  out  N_IN  debounced levels.
- rise  out  N_IN  one-clk pulse when in_clean bit goes 0->1.
- fall  out  N_IN  one-clk pulse when in_clean bit goes 1->0.
- changed  out  1  OR of all rise and fall bits, same cycle.

Behaviour:
- Reset: clears all state immediately on rst rising, with no clk required.
  - sync stages = 0, in_clean = 0, rise = fall = 0, changed = 0, counters = 0, all channels in STABLE.
- Synchroniser: 2-FF chain per bit; s = second stage. Raw-to-s latency is 2 clk.
- Per-channel FSM, channels fully independent:
  - STABLE
    - If s == in_clean: stay; cnt held at 0.
    - If s != in_clean: go to QUAL; cnt = 0.
  - QUAL
    - If s == in_clean on any clk: this is a glitch. Return to STABLE, cnt = 0, no strobe.
    - Else, on a clk with tick_1MHz = 1:
      - If cnt == DEB_TICKS-1: in_clean bit toggles on that edge; go to STABLE; cnt = 0.
      - Otherwise cnt = cnt + 1.
    - Else, with tick_1MHz = 0: cnt holds.
- Strobes:
  - rise/fall assert for exactly the one clk in which the new in_clean value is first visible.
  - Both are registered: asserted in the same cycle in_clean changes.
- Acceptance latency: 2 clk (sync) + 1 clk (STABLE->QUAL) + DEB_TICKS ticks, counting ticks from the first tick seen in QUAL.
- Tick coincident with the STABLE->QUAL transition: not counted. Counting starts in QUAL.
- Glitch and tick in the same clk: the glitch wins; no acceptance.
- DEB_TICKS = 1: accept on the first tick seen in QUAL.
- tick_1MHz stuck at 0: in_clean never changes; no overflow, since cnt only advances on tick.
- Simultaneous channels: any combination of channels may strobe in the same clk; changed is asserted once.
- Input held 1 through reset release: in_clean rises after normal latency and produces a rise pulse (in_clean resets to 0).
- rst asserted mid-QUAL: aborts the qualification. No strobe is generated, then or on deassertion.
- rise and fall are mutually exclusive per bit.

Optional Feature:
- Macro: GLUE_COND_GLITCH_CNT_EN.
- Defined:
  - Adds output port glitch_cnt [7:0], reset to 0.
  - Increments by 1 on every clk in which at least one channel takes QUAL->STABLE via the glitch path. Multiple channels glitching in the same clk count once.
  - Saturates at 255.
  - Cleared only by rst.
- Undefined:
  - Port absent; no counter logic.
  - All other behaviour identical.

Test Plan:
- Reset/idle: rst=1 for 3 clk with in_raw=4'b1111 -> all outputs 0 during reset. After release, tick every 50 clk: in_clean = 4'b1111 with rise = 4'b1111 for one clk, at 3 clk + 10 ticks after release; changed = 1 that clk.
- Clean rise: in_raw[0] 0->1 held, DEB_TICKS=10 -> in_clean[0] = 1 and rise[0] pulse for exactly 1 clk after the 10th tick; fall stays 0; other bits unchanged.
- Glitch reject: in_raw[2] pulses high for 9 ticks (450 clk) then returns low -> in_clean[2] stays 0, no strobes. With GLUE_COND_GLITCH_CNT_EN: glitch_cnt = 1.
- Simultaneous fall: in_clean = 4'b1111, in_raw -> 4'b0000 at once -> fall = 4'b1111 in a single clk; changed = 1 for that clk only.
- Reset mid-qualify: in_raw[1] high for 5 ticks, assert rst asynchronously between clk edges -> outputs 0 immediately. After release with in_raw[1] still high: rise[1] appears after the full latency again, not after the 5 remaining ticks.
- Glitch counter saturation (macro on): 300 sub-threshold pulses on in_raw[3] -> glitch_cnt = 255 and holds.

Source files
------------

// File: rtl/glue_input_conditioner_if.sv
// Conditioned glue-logic input bus: raw pins and 1 MHz enable in, clean levels and strobes out.
// glitch_cnt exists only when GLUE_COND_GLITCH_CNT_EN is defined.
interface glue_input_conditioner_if #(
    parameter int N_IN = 4
);
    logic            tick_1MHz;
    logic [N_IN-1:0] in_raw;
    logic [N_IN-1:0] in_clean;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic            changed;
`ifdef GLUE_COND_GLITCH_CNT_EN
    logic [7:0]      glitch_cnt;
`endif

    modport master (
        output tick_1MHz,
        output in_raw,
        input  in_clean,
        input  rise,
        input  fall,
`ifdef GLUE_COND_GLITCH_CNT_EN
        input  glitch_cnt,
`endif
        input  changed
    );

    modport slave (
        input  tick_1MHz,
        input  in_raw,
        output in_clean,
        output rise,
        output fall,
`ifdef GLUE_COND_GLITCH_CNT_EN
        output glitch_cnt,
`endif
        output changed
    );
endinterface

// File: rtl/glue_input_conditioner.sv
// Glue input front end: 2-FF synchroniser, per-channel tick-based debounce FSM, registered edge strobes.
// Optional saturating glitch counter enabled by GLUE_COND_GLITCH_CNT_EN.
module glue_input_conditioner #(
    parameter int N_IN      = 4,
    parameter int DEB_TICKS = 10,
    parameter int CNT_W     = 8
) (
    input logic                     clk,
    input logic                     rst,
    glue_input_conditioner_if.slave bus
);
    typedef enum logic {STABLE = 1'b0, QUAL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic [N_IN-1:0]  sync_p0;
    logic [N_IN-1:0]  sync_p1;
    logic [N_IN-1:0]  clean_q;
    logic [N_IN-1:0]  rise_q;
    logic [N_IN-1:0]  fall_q;
    logic             changed_q;
    state_t           state_q [N_IN];
    logic [CNT_W-1:0] cnt_q   [N_IN];
    logic [N_IN-1:0]  accept;
    logic [N_IN-1:0]  glitch;

    // A glitch is checked before the tick, so a glitch coincident with the final tick never accepts.
    always_comb begin
        accept = '0;
        glitch = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (state_q[i] == QUAL) begin
                if (sync_p1[i] == clean_q[i])
                    glitch[i] = 1'b1;
                else if (bus.tick_1MHz && (cnt_q[i] == CNT_LAST))
                    accept[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            // sync stage boundary: raw pin -> p0 -> p1
            sync_p0   <= bus.in_raw;
            sync_p1   <= sync_p0;
            // output stage boundary: strobes are registered alongside the new clean level
            clean_q   <= clean_q ^ accept;
            rise_q    <= accept & ~clean_q;
            fall_q    <= accept & clean_q;
            changed_q <= |accept;
            for (int i = 0; i < N_IN; i++) begin
                case (state_q[i])
                    STABLE: begin
                        cnt_q[i] <= '0;
                        if (sync_p1[i] != clean_q[i])
                            state_q[i] <= QUAL;
                    end
                    QUAL: begin
                        if (glitch[i] || accept[i]) begin
                            state_q[i] <= STABLE;
                            cnt_q[i]   <= '0;
                        end else if (bus.tick_1MHz) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= STABLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.in_clean = clean_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.changed  = changed_q;

`ifdef GLUE_COND_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q;

    // Counts clocks with any glitch, not glitching channels; sticks at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            glitch_cnt_q <= '0;
        else if ((|glitch) && (glitch_cnt_q != 8'hFF))
            glitch_cnt_q <= glitch_cnt_q + 8'd1;
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif
endmodule

// File: tb/tb_glue_input_conditioner.sv
// Directed bench for glue_input_conditioner: reset, debounce latency, glitch rejection, strobes,
// stuck tick, reset during qualification and (with GLUE_COND_GLITCH_CNT_EN) glitch counter saturation.
module tb_glue_input_conditioner;
    localparam int N_IN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tick_total = 0;
    int   div = 0;
    bit   tick_en = 1'b1;

    glue_input_conditioner_if #(.N_IN(N_IN)) bus ();

    glue_input_conditioner #(
        .N_IN(N_IN),
        .DEB_TICKS(10),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    // 1 MHz enable: one clk wide, every 50 clk, changed on the falling edge
    initial begin
        bus.tick_1MHz = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 49) ? 0 : div + 1;
            bus.tick_1MHz = tick_en && (div == 49);
        end
    end

    always @(posedge clk) if (bus.tick_1MHz) tick_total <= tick_total + 1;

    // Leaves the bench on a falling edge whose next tick lands on the 50th rising edge.
    task automatic align_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (bus.tick_1MHz) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL align_tick: no tick seen within 200 clk, required a tick");
        end
    endtask

    task automatic wait_clean(input logic [3:0] exp, input int max_cyc, output int cyc, output int nt,
                              output logic [3:0] r, output logic [3:0] f, output logic c, output bit early);
        int t0;
        t0    = tick_total;
        cyc   = 0;
        early = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.in_clean === exp || cyc >= max_cyc) break;
            if (bus.rise !== '0 || bus.fall !== '0 || bus.changed !== 1'b0) early = 1'b1;
        end
        nt = tick_total - t0;
        r  = bus.rise;
        f  = bus.fall;
        c  = bus.changed;
    endtask

    task automatic test_reset();
        int cyc, nt;
        logic [3:0] r, f;
        logic c;
        bit early;
        bus.in_raw = 4'b1111;
        #5 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b, required all zero",
                         {bus.in_clean, bus.rise, bus.fall, bus.changed});
            end
        end
        align_tick();
        rst = 1'b0;
        wait_clean(4'b1111, 700, cyc, nt, r, f, c, early);
        checks++;
        if ({bus.in_clean, r, f, c} !== {4'b1111, 4'b1111, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_rise: got clean/rise/fall/chg %b, required 1111_1111_0000_1",
                     {bus.in_clean, r, f, c});
        end
        checks++;
        if (cyc != 500 || nt != 10) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d clk / %0d ticks, required 500 / 10", cyc, nt);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL reset_release_early: got strobe before acceptance, required none");
        end
        @(negedge clk);
        checks++;
        if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b1111, 9'b0}) begin
            errors++;
            $display("FAIL reset_release_pulse_width: got %b, required 1111_0000_0000_0",
                     {bus.in_clean, bus.rise, bus.fall, bus.changed});
        end
`ifdef GLUE_COND_GLITCH_CNT_EN
        checks++;
        if (bus.glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_glitch_cnt: got %0d, required 0", bus.glitch_cnt);
        end
`endif
    endtask

    task automatic test_simultaneous_fall();
        int cyc, nt;
        logic [3:0] r, f;
        logic c;
        bit early;
        align_tick();
        bus.in_raw = 4'b0000;
        wait_clean(4'b0000, 700, cyc, nt, r, f, c, early);
        checks++;
        if ({bus.in_clean, r, f, c} !== {4'b0000, 4'b0000, 4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL simul_fall: got clean/rise/fall/chg %b, required 0000_0000_1111_1",
                     {bus.in_clean, r, f, c});
        end
        checks++;
        if (cyc != 500 || nt != 10 || early) begin
            errors++;
            $display("FAIL simul_fall_latency: got %0d clk / %0d ticks / early %0d, required 500 / 10 / 0",
                     cyc, nt, early);
        end
        @(negedge clk);
        checks++;
        if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== 13'b0) begin
            errors++;
            $display("FAIL simul_fall_pulse_width: got %b, required all zero",
                     {bus.in_clean, bus.rise, bus.fall, bus.changed});
        end
    endtask

    task automatic test_clean_rise();
        int cyc, nt;
        logic [3:0] r, f;
        logic c;
        bit early;
        align_tick();
        bus.in_raw = 4'b0001;
        wait_clean(4'b0001, 700, cyc, nt, r, f, c, early);
        checks++;
        if ({bus.in_clean, r, f, c} !== {4'b0001, 4'b0001, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL clean_rise: got clean/rise/fall/chg %b, required 0001_0001_0000_1",
                     {bus.in_clean, r, f, c});
        end
        checks++;
        if (cyc != 500 || nt != 10 || early) begin
            errors++;
            $display("FAIL clean_rise_latency: got %0d clk / %0d ticks / early %0d, required 500 / 10 / 0",
                     cyc, nt, early);
        end
        @(negedge clk);
        checks++;
        if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b0001, 9'b0}) begin
            errors++;
            $display("FAIL clean_rise_pulse_width: got %b, required 0001_0000_0000_0",
                     {bus.in_clean, bus.rise, bus.fall, bus.changed});
        end
    endtask

    task automatic test_glitch_reject();
        int bad;
        bad = 0;
        align_tick();
        bus.in_raw = 4'b0101;
        for (int i = 0; i < 550; i++) begin
            @(negedge clk);
            if (i == 449) bus.in_raw = 4'b0001;
            if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b0001, 9'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d deviating clk, required 0 (clean 0001, no strobes)", bad);
        end
`ifdef GLUE_COND_GLITCH_CNT_EN
        checks++;
        if (bus.glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_reject_cnt: got %0d, required 1", bus.glitch_cnt);
        end
`endif
    endtask

    task automatic test_tick_stuck();
        int bad;
        bad = 0;
        tick_en = 1'b0;
        @(negedge clk);
        bus.in_raw = 4'b1001;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b0001, 9'b0}) bad++;
        end
        bus.in_raw = 4'b0001;
        repeat (5) @(negedge clk);
        tick_en = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tick_stuck: got %0d deviating clk, required 0", bad);
        end
`ifdef GLUE_COND_GLITCH_CNT_EN
        checks++;
        if (bus.glitch_cnt !== 8'd2) begin
            errors++;
            $display("FAIL tick_stuck_glitch_cnt: got %0d, required 2", bus.glitch_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_qual();
        int cyc, nt;
        logic [3:0] r, f;
        logic c;
        bit early;
        align_tick();
        bus.in_raw = 4'b0011;
        repeat (260) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== 13'b0) begin
            errors++;
            $display("FAIL reset_async: got %b, required all zero",
                     {bus.in_clean, bus.rise, bus.fall, bus.changed});
        end
`ifdef GLUE_COND_GLITCH_CNT_EN
        checks++;
        if (bus.glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_async_glitch_cnt: got %0d, required 0", bus.glitch_cnt);
        end
`endif
        repeat (3) @(negedge clk);
        align_tick();
        rst = 1'b0;
        wait_clean(4'b0011, 700, cyc, nt, r, f, c, early);
        checks++;
        if ({bus.in_clean, r, f, c} !== {4'b0011, 4'b0011, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_qual_rise: got clean/rise/fall/chg %b, required 0011_0011_0000_1",
                     {bus.in_clean, r, f, c});
        end
        checks++;
        if (cyc != 500 || nt != 10 || early) begin
            errors++;
            $display("FAIL reset_mid_qual_latency: got %0d clk / %0d ticks / early %0d, required 500 / 10 / 0",
                     cyc, nt, early);
        end
        @(negedge clk);
        checks++;
        if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b0011, 9'b0}) begin
            errors++;
            $display("FAIL reset_mid_qual_pulse_width: got %b, required 0011_0000_0000_0",
                     {bus.in_clean, bus.rise, bus.fall, bus.changed});
        end
    endtask

`ifdef GLUE_COND_GLITCH_CNT_EN
    task automatic test_glitch_saturation();
        int bad;
        bad = 0;
        for (int p = 0; p < 300; p++) begin
            bus.in_raw = 4'b1011;
            repeat (4) @(negedge clk);
            bus.in_raw = 4'b0011;
            repeat (4) @(negedge clk);
            if ({bus.in_clean, bus.rise, bus.fall, bus.changed} !== {4'b0011, 9'b0}) bad++;
            if (p == 99) begin
                checks++;
                if (bus.glitch_cnt !== 8'd100) begin
                    errors++;
                    $display("FAIL glitch_cnt_100: got %0d, required 100", bus.glitch_cnt);
                end
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.glitch_cnt !== 8'd255) begin
            errors++;
            $display("FAIL glitch_cnt_saturate: got %0d, required 255", bus.glitch_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_cnt_no_strobe: got %0d deviating samples, required 0", bad);
        end
    endtask
`endif

    initial begin
        bus.in_raw = 4'b0000;
        test_reset();
        test_simultaneous_fall();
        test_clean_rise();
        test_glitch_reject();
        test_tick_stuck();
        test_reset_mid_qual();
`ifdef GLUE_COND_GLITCH_CNT_EN
        test_glitch_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
